// File: rtl/line_drawer_if.sv
// rtl/line_drawer_if.sv - host register bus and pixel write stream bundle for line_drawer_engine
interface line_drawer_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 24
);
    logic [2:0]         avs_address;
    logic               avs_read;
    logic               avs_write;
    logic [31:0]        avs_writedata;
    logic [31:0]        avs_readdata;
    logic               avs_waitrequest;
    logic               px_valid;
    logic               px_ready;
    logic [X_W-1:0]     px_x;
    logic [Y_W-1:0]     px_y;
    logic [COLOR_W-1:0] px_color;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, px_ready,
        output avs_readdata, avs_waitrequest, px_valid, px_x, px_y, px_color
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, px_ready,
        input  avs_readdata, avs_waitrequest, px_valid, px_x, px_y, px_color
    );
endinterface

// File: rtl/line_drawer_engine.sv
// rtl/line_drawer_engine.sv - register-driven Bresenham line / filled rectangle rasteriser with clipping
module line_drawer_engine #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 24,
    parameter int H_RES   = 320,
    parameter int V_RES   = 240
) (
    input  logic         clk,
    input  logic         reset,
    line_drawer_if.slave bus
);
    localparam int E_W = ((X_W > Y_W) ? X_W : Y_W) + 2;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

    state_t              r_state;
    logic                r_mode, r_shape, r_go_held;
    logic [X_W-1:0]      r_sx, r_ex;
    logic [Y_W-1:0]      r_sy, r_ey;
    logic [COLOR_W-1:0]  r_color, r_wcolor;
    logic [31:0]         r_count;
    logic                r_wshape, r_xdec, r_ydec;
    logic [X_W-1:0]      r_cur_x, r_end_x, r_xmin;
    logic [Y_W-1:0]      r_cur_y, r_end_y;
    logic signed [E_W-1:0] r_dx, r_dy, r_err;

    logic                w_busy, w_go_wr, w_wait, w_wr_ok, w_go_start;
    logic                w_clip, w_retire, w_last, w_stepx, w_stepy;
    logic signed [E_W-1:0] w_e2, w_err_nx, w_adx, w_ady;
    logic [X_W-1:0]      w_ux, w_xmin, w_xmax;
    logic [Y_W-1:0]      w_uy, w_ymin, w_ymax;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_busy  = (r_state != S_IDLE);
    assign w_go_wr = bus.avs_write && (bus.avs_address == 3'd2);
    // A stalled GO starts the op immediately but is only acknowledged once the op is done
    assign w_wait  = !reset && !r_mode && (bus.avs_read || bus.avs_write)
                     && (w_busy || (w_go_wr && !r_go_held));
    assign w_wr_ok    = bus.avs_write && !w_wait;
    assign w_go_start = (r_state == S_IDLE) && w_go_wr && (r_mode || !r_go_held);

    assign w_clip   = (int'(r_cur_x) >= H_RES) || (int'(r_cur_y) >= V_RES);
    assign w_retire = (r_state == S_DRAW) && (w_clip || bus.px_ready);
    assign w_last   = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);

    assign w_e2     = r_err <<< 1;
    assign w_stepx  = (w_e2 >= r_dy);
    assign w_stepy  = (w_e2 <= r_dx);
    assign w_err_nx = r_err + (w_stepx ? r_dy : '0) + (w_stepy ? r_dx : '0);

    assign w_ux   = (r_ex >= r_sx) ? r_ex - r_sx : r_sx - r_ex;
    assign w_uy   = (r_ey >= r_sy) ? r_ey - r_sy : r_sy - r_ey;
    assign w_adx  = $signed({{(E_W-X_W){1'b0}}, w_ux});
    assign w_ady  = $signed({{(E_W-Y_W){1'b0}}, w_uy});
    assign w_xmin = (r_sx < r_ex) ? r_sx : r_ex;
    assign w_xmax = (r_sx < r_ex) ? r_ex : r_sx;
    assign w_ymin = (r_sy < r_ey) ? r_sy : r_ey;
    assign w_ymax = (r_sy < r_ey) ? r_ey : r_sy;

    always_comb begin
        w_rdata = '0;
        case (bus.avs_address)
            3'd0: w_rdata[0] = r_mode;
            3'd1: w_rdata[0] = w_busy;
            3'd3: begin w_rdata[X_W-1:0] = r_sx; w_rdata[16 +: Y_W] = r_sy; end
            3'd4: begin w_rdata[X_W-1:0] = r_ex; w_rdata[16 +: Y_W] = r_ey; end
            3'd5: w_rdata[COLOR_W-1:0] = r_color;
            3'd6: w_rdata[0] = r_shape;
            3'd7: w_rdata = r_count;
            default: w_rdata = '0;
        endcase
    end

    assign bus.avs_readdata    = w_rdata;
    assign bus.avs_waitrequest = w_wait;
    assign bus.px_valid        = (r_state == S_DRAW) && !w_clip;
    assign bus.px_x            = r_cur_x;
    assign bus.px_y            = r_cur_y;
    assign bus.px_color        = r_wcolor;
    assign w_unused            = &{1'b0, bus.avs_writedata};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode <= 1'b0; r_shape <= 1'b0; r_go_held <= 1'b0;
            r_sx <= '0; r_ex <= '0; r_sy <= '0; r_ey <= '0;
            r_color <= '0; r_wcolor <= '0; r_count <= '0;
            r_wshape <= 1'b0; r_xdec <= 1'b0; r_ydec <= 1'b0;
            r_cur_x <= '0; r_end_x <= '0; r_xmin <= '0;
            r_cur_y <= '0; r_end_y <= '0;
            r_dx <= '0; r_dy <= '0; r_err <= '0;
        end else begin
            if (w_wr_ok) begin
                case (bus.avs_address)
                    3'd0: r_mode <= bus.avs_writedata[0];
                    3'd3: begin r_sx <= bus.avs_writedata[X_W-1:0]; r_sy <= bus.avs_writedata[16 +: Y_W]; end
                    3'd4: begin r_ex <= bus.avs_writedata[X_W-1:0]; r_ey <= bus.avs_writedata[16 +: Y_W]; end
                    3'd5: r_color <= bus.avs_writedata[COLOR_W-1:0];
                    3'd6: r_shape <= bus.avs_writedata[0];
                    default: ;
                endcase
            end

            if (w_go_start && !r_mode)
                r_go_held <= 1'b1;
            else if (w_go_wr && !w_wait)
                r_go_held <= 1'b0;

            case (r_state)
                S_IDLE: if (w_go_start) r_state <= S_SETUP;
                S_SETUP: begin
                    r_wcolor <= r_color;
                    r_wshape <= r_shape;
                    r_count  <= '0;
                    r_xdec   <= (r_ex < r_sx);
                    r_ydec   <= (r_ey < r_sy);
                    r_dx     <= w_adx;
                    r_dy     <= -w_ady;
                    r_err    <= w_adx - w_ady;
                    if (r_shape) begin
                        r_cur_x <= w_xmin; r_xmin <= w_xmin; r_end_x <= w_xmax;
                        r_cur_y <= w_ymin; r_end_y <= w_ymax;
                    end else begin
                        r_cur_x <= r_sx; r_xmin <= r_sx; r_end_x <= r_ex;
                        r_cur_y <= r_sy; r_end_y <= r_ey;
                    end
                    r_state <= S_DRAW;
                end
                S_DRAW: if (w_retire) begin
                    if (!w_clip && (r_count != 32'hFFFF_FFFF))
                        r_count <= r_count + 32'd1;
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end else if (r_wshape) begin
                        if (r_cur_x == r_end_x) begin
                            r_cur_x <= r_xmin;
                            r_cur_y <= r_cur_y + Y_W'(1);
                        end else begin
                            r_cur_x <= r_cur_x + X_W'(1);
                        end
                    end else begin
                        // Both axis decisions use the same e2 so diagonal steps happen in one cycle
                        if (w_stepx) r_cur_x <= r_xdec ? r_cur_x - X_W'(1) : r_cur_x + X_W'(1);
                        if (w_stepy) r_cur_y <= r_ydec ? r_cur_y - Y_W'(1) : r_cur_y + Y_W'(1);
                        r_err <= w_err_nx;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_drawer_engine.sv
// tb/tb_line_drawer_engine.sv - directed self-checking bench for line_drawer_engine
module tb_line_drawer_engine;
    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int COLOR_W = 24;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    line_drawer_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) bus ();

    line_drawer_engine #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .H_RES(320), .V_RES(240)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] c;
    } px_t;

    px_t q[$];
    time last_acc_t = 0;

    always @(negedge clk) begin
        if (bus.px_valid && bus.px_ready) begin
            q.push_back('{bus.px_x, bus.px_y, bus.px_color});
            last_acc_t = $time;
        end
    end

    typedef struct {
        int x0, y0, x1, y1, shape, color, npx, busy;
        int ex[8];
        int ey[8];
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        int n;
        bus.avs_address = 3'(a); bus.avs_writedata = d; bus.avs_write = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.avs_waitrequest && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL write_timeout addr=%0d waited=%0d required<200", a, n);
        end
        @(posedge clk); #1;
        bus.avs_write = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        int n;
        bus.avs_address = 3'(a); bus.avs_read = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.avs_waitrequest && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL read_timeout addr=%0d waited=%0d required<200", a, n);
        end
        d = bus.avs_readdata;
        @(posedge clk); #1;
        bus.avs_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required=finish_before_limit", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int nb, n;
        time go_done_t;

        vt[0] = '{0, 0, 3, 0, 0, 'h5A, 4, 5, '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};
        vt[1] = '{0, 0, 4, 2, 0, 'h123456, 5, 6, '{0, 1, 2, 3, 4, 0, 0, 0}, '{0, 1, 1, 2, 2, 0, 0, 0}};
        vt[2] = '{5, 5, 2, 2, 0, 'hABCDEF, 4, 5, '{5, 4, 3, 2, 0, 0, 0, 0}, '{5, 4, 3, 2, 0, 0, 0, 0}};
        vt[3] = '{7, 9, 7, 9, 0, 'h00FF00, 1, 2, '{7, 0, 0, 0, 0, 0, 0, 0}, '{9, 0, 0, 0, 0, 0, 0, 0}};
        vt[4] = '{2, 2, 1, 1, 1, 'h0F0F0F, 4, 5, '{1, 2, 1, 2, 0, 0, 0, 0}, '{1, 1, 2, 2, 0, 0, 0, 0}};
        vt[5] = '{318, 0, 322, 0, 0, 'hFFFFFF, 2, 6, '{318, 319, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};
        vt[6] = '{0, 0, 1, 3, 0, 'h010203, 4, 5, '{0, 0, 1, 1, 0, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0}};
        vt[7] = '{0, 238, 1, 241, 1, 'h445566, 4, 9, '{0, 1, 0, 1, 0, 0, 0, 0}, '{238, 238, 239, 239, 0, 0, 0, 0}};

        bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        bus.avs_writedata = '0; bus.px_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_px_valid", 32'(bus.px_valid), 0);
        chk("rst_px_x", 32'(bus.px_x), 0);
        chk("rst_px_color", 32'(bus.px_color), 0);
        chk("rst_waitrequest", 32'(bus.avs_waitrequest), 0);
        @(posedge clk); #1;
        bus_read(0, d); chk("rst_mode", d, 0);
        bus_read(1, d); chk("rst_status", d, 0);
        bus_read(7, d); chk("rst_count", d, 0);
        bus_read(3, d); chk("rst_start", d, 0);

        // GO at cycle N: SETUP (no pixel) at N+1, first pixel at N+2
        bus_write(0, 1);
        bus_write(3, 0); bus_write(4, 0);
        bus_write(2, 0);
        @(negedge clk); chk("lat_px_valid_n1", 32'(bus.px_valid), 0);
        @(negedge clk); chk("lat_px_valid_n2", 32'(bus.px_valid), 1);
        repeat (3) @(posedge clk); #1;
        bus_read(1, d); chk("lat_status_after", d, 0);

        for (int i = 0; i < 8; i++) begin
            bus_write(3, (vt[i].y0 << 16) | vt[i].x0);
            bus_write(4, (vt[i].y1 << 16) | vt[i].x1);
            bus_write(5, vt[i].color);
            bus_write(6, vt[i].shape);
            q.delete();
            bus_write(2, 0);
            nb = 0;
            for (int k = 0; k < 100; k++) begin
                bus_read(1, d);
                if (d[0]) nb++;
                else break;
            end
            chk($sformatf("v%0d_busy_cycles", i), nb, vt[i].busy);
            chk($sformatf("v%0d_px_count", i), q.size(), vt[i].npx);
            for (int j = 0; j < vt[i].npx; j++) begin
                if (j < q.size()) begin
                    chk($sformatf("v%0d_px%0d_x", i, j), 32'(q[j].x), vt[i].ex[j]);
                    chk($sformatf("v%0d_px%0d_y", i, j), 32'(q[j].y), vt[i].ey[j]);
                    chk($sformatf("v%0d_px%0d_color", i, j), 32'(q[j].c), vt[i].color);
                end
            end
            bus_read(7, d); chk($sformatf("v%0d_count_reg", i), d, vt[i].npx);
        end

        // Stall mode with a 5-cycle backpressure gap on the third pixel
        bus_write(0, 0);
        bus_write(3, 0); bus_write(4, 3); bus_write(5, 'h33); bus_write(6, 0);
        q.delete();
        go_done_t = 0;
        fork
            begin
                bus_write(2, 0);
                go_done_t = $time;
            end
            begin
                n = 0;
                while (q.size() < 2 && n < 50) begin @(negedge clk); #1; n++; end
                chk("stall_reach_px2", 32'(q.size()), 2);
                @(posedge clk); #1 bus.px_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk($sformatf("freeze%0d_x", k), 32'(bus.px_x), 2);
                    chk($sformatf("freeze%0d_valid", k), 32'(bus.px_valid), 1);
                    chk($sformatf("freeze%0d_wait", k), 32'(bus.avs_waitrequest), 1);
                end
                @(posedge clk); #1 bus.px_ready = 1'b1;
            end
        join
        chk("stall_px_count", q.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < q.size()) begin
                chk($sformatf("stall_px%0d_x", j), 32'(q[j].x), j);
                chk($sformatf("stall_px%0d_color", j), 32'(q[j].c), 'h33);
            end
        end
        chk("stall_go_after_last_px", 32'(go_done_t > last_acc_t), 1);
        bus_read(7, d); chk("stall_count_reg", d, 4);
        bus_read(1, d); chk("stall_status", d, 0);

        // One-cycle reset in the middle of a 10-pixel line
        bus_write(0, 1);
        bus_write(3, 0); bus_write(4, 9); bus_write(5, 'h99);
        q.delete();
        bus_write(2, 0);
        n = 0;
        while (q.size() < 2 && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        reset = 1'b1; bus.px_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; bus.px_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_px_valid", 32'(bus.px_valid), 0);
        @(posedge clk); #1;
        bus_read(1, d); chk("rstmid_status", d, 0);
        bus_read(7, d); chk("rstmid_count", d, 0);
        bus_read(4, d); chk("rstmid_end_reg", d, 0);
        bus_read(0, d); chk("rstmid_mode", d, 0);
        repeat (5) @(posedge clk); #1;
        chk("rstmid_no_more_px", q.size(), 2);
        bus_write(3, 32'h0001_0001); bus_write(4, 32'h0001_0002); bus_write(5, 'h77);
        q.delete();
        bus_write(2, 0);
        chk("rstmid_new_px_count", q.size(), 2);
        for (int j = 0; j < 2; j++) begin
            if (j < q.size()) begin
                chk($sformatf("rstmid_new_px%0d_x", j), 32'(q[j].x), j + 1);
                chk($sformatf("rstmid_new_px%0d_y", j), 32'(q[j].y), 1);
            end
        end
        bus_read(7, d); chk("rstmid_new_count", d, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
